// File: rtl/branch_flag_unit.sv
// branch_flag_unit: registers the ALU carry/zero/negative status, feeds the
// carry back to the ALU, evaluates conditional branches on the registered
// flags and owns the program counter through an IDLE/RUN/REDIRECT/HALTED FSM.
module branch_flag_unit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             alu_wr,
    input  logic             cmp_wr,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [OFF_W-1:0] br_off,
    input  logic             halt,
    output logic             c_flag,
    output logic             z_flag,
    output logic             n_flag,
    output logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic             flush,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state;

    // Branch condition decode against the registered flags; 111 is reserved.
    function automatic logic cond_met(input logic [2:0] cond,
                                      input logic c, input logic z,
                                      input logic n);
        logic hit;
        case (cond)
            3'b000:  hit = 1'b1;
            3'b001:  hit = z;
            3'b010:  hit = !z;
            3'b011:  hit = n;
            3'b100:  hit = !z && !n;
            3'b101:  hit = c;
            3'b110:  hit = !c;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Offset is two's complement; the size cast of a signed value sign-extends,
    // and the add below wraps modulo 2^PC_W in both directions.
    logic signed [OFF_W-1:0] off_s;
    logic        [PC_W-1:0]  off_ext;
    logic        [PC_W-1:0]  pc_target;
    logic        [PC_W-1:0]  pc_next_seq;
    logic                    br_hit;

    assign off_s       = br_off;
    assign off_ext     = PC_W'(off_s);
    assign pc_target   = pc + off_ext;
    assign pc_next_seq = pc + PC_W'(1);
    assign br_hit      = br_valid && cond_met(br_cond, c_flag, z_flag, n_flag);

    // Status flags: written in every state (stall included), no forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else begin
            if (alu_wr) begin
                c_flag <= alu_c;
            end
            if (cmp_wr) begin
                z_flag <= alu_z;
                n_flag <= alu_n;
            end
        end
    end

    // Sequencing FSM with registered pc, taken, flush and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            taken <= 1'b0;
            flush <= 1'b0;
            done  <= 1'b0;
        end else begin
            taken <= 1'b0;
            case (state)
                IDLE: begin
                    flush <= 1'b0;
                    done  <= 1'b0;
                    pc    <= '0;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    flush <= 1'b0;
                    if (stall) begin
                        state <= RUN;
                    end else if (halt) begin
                        state <= HALTED;
                        done  <= 1'b1;
                    end else if (br_hit) begin
                        pc    <= pc_target;
                        taken <= 1'b1;
                        flush <= 1'b1;
                        state <= REDIRECT;
                    end else begin
                        pc <= pc_next_seq;
                    end
                end
                REDIRECT: begin
                    // The fetch slot at the target is discarded; a stall keeps
                    // the redirect (and its flush) alive for another cycle.
                    if (stall) begin
                        flush <= 1'b1;
                    end else begin
                        flush <= 1'b0;
                        state <= RUN;
                    end
                end
                HALTED: begin
                    flush <= 1'b0;
                    if (start) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        state <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    pc    <= '0;
                    flush <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Testbench for branch_flag_unit: directed vector table followed by
// randomized stimulus compared against a behavioural model.
module tb_branch_flag_unit;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int PC_MOD = 1 << PC_W;

    logic             clk;
    logic             reset, start, stall, alu_wr, cmp_wr;
    logic             alu_c, alu_z, alu_n, br_valid, halt;
    logic [2:0]       br_cond;
    logic [OFF_W-1:0] br_off;
    logic             c_flag, z_flag, n_flag, taken, flush, done;
    logic [PC_W-1:0]  pc;

    int checks = 0;
    int errors = 0;

    branch_flag_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .alu_wr(alu_wr), .cmp_wr(cmp_wr), .alu_c(alu_c), .alu_z(alu_z),
        .alu_n(alu_n), .br_valid(br_valid), .br_cond(br_cond),
        .br_off(br_off), .halt(halt), .c_flag(c_flag), .z_flag(z_flag),
        .n_flag(n_flag), .pc(pc), .taken(taken), .flush(flush), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, stl, aw, cw, c, z, n, bv;
        logic [2:0] cond;
        logic [7:0] off;
        logic       hlt;
        int         e_pc;
        logic       e_t, e_f, e_d, e_c, e_z, e_n;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic st, logic stl, logic aw,
                                logic cw, logic c, logic z, logic n,
                                logic bv, logic [2:0] cond, logic [7:0] off,
                                logic hlt, int e_pc, logic e_t, logic e_f,
                                logic e_d, logic e_c, logic e_z, logic e_n);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.aw = aw; v.cw = cw;
        v.c = c; v.z = z; v.n = n; v.bv = bv; v.cond = cond; v.off = off;
        v.hlt = hlt; v.e_pc = e_pc; v.e_t = e_t; v.e_f = e_f; v.e_d = e_d;
        v.e_c = e_c; v.e_z = e_z; v.e_n = e_n;
        return v;
    endfunction

    task automatic compare(string name, int exp_pc, logic et, logic ef,
                           logic ed, logic ec, logic ez, logic en);
        logic [15:0] act, expv;
        act  = {3'b0, pc, taken, flush, done};
        expv = {3'b0, PC_W'(exp_pc), et, ef, ed};
        checks++;
        if (act !== expv || {c_flag, z_flag, n_flag} !== {ec, ez, en}) begin
            errors++;
            $display("FAIL %s: got pc=%0d t=%b f=%b d=%b czn=%b%b%b, want pc=%0d t=%b f=%b d=%b czn=%b%b%b",
                     name, pc, taken, flush, done, c_flag, z_flag, n_flag,
                     exp_pc, et, ef, ed, ec, ez, en);
        end
    endtask

    // Behavioural model state (IDLE=0, RUN=1, REDIRECT=2, HALTED=3)
    int   m_st, m_pc;
    logic m_c, m_z, m_n, m_t, m_f, m_d;

    function automatic logic m_cond(logic [2:0] cd, logic c, logic z, logic n);
        case (cd)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !z && !n;
            3'd5: return c;
            3'd6: return !c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic hit;
        int   off;
        hit = br_valid && m_cond(br_cond, m_c, m_z, m_n);
        off = int'($signed(br_off));
        if (reset) begin
            m_st = 0; m_pc = 0; m_c = 0; m_z = 0; m_n = 0;
            m_t = 0; m_f = 0; m_d = 0;
            return;
        end
        if (alu_wr) m_c = alu_c;
        if (cmp_wr) begin m_z = alu_z; m_n = alu_n; end
        m_t = 0;
        case (m_st)
            0: begin m_f = 0; m_d = 0; if (start) m_st = 1; end
            1: begin
                m_f = 0;
                if (stall) ;
                else if (halt) begin m_st = 3; m_d = 1; end
                else if (hit) begin
                    m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
                    m_t = 1; m_f = 1; m_st = 2;
                end else m_pc = (m_pc + 1) % PC_MOD;
            end
            2: begin
                if (stall) m_f = 1;
                else begin m_f = 0; m_st = 1; end
            end
            default: begin
                m_f = 0;
                if (start) begin m_pc = 0; m_d = 0; m_st = 1; end
            end
        endcase
    endtask

    initial begin
        reset = 1; start = 0; stall = 0; alu_wr = 0; cmp_wr = 0;
        alu_c = 0; alu_z = 0; alu_n = 0; br_valid = 0; br_cond = 0;
        br_off = 0; halt = 0;

        //        rst st stl aw cw c  z  n  bv cond  off    h   pc  t  f  d  c  z  n
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0)); // reset
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0)); // start
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   1,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   2,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   3,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,1,0,0,3'd0,8'h00,0,   4,0,0,0,0,1,0)); // cmp z=1
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd1,8'hFD,0,   1,1,1,0,0,1,0)); // beq -3
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   1,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   2,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0,3'd0,8'h00,0,   3,0,0,0,0,0,0)); // z=0
        tbl.push_back(mk(0,0,0,0,1,0,1,0,1,3'd1,8'h05,0,   4,0,0,0,0,1,0)); // no forward
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd1,8'h05,0,   9,1,1,0,0,1,0)); // now taken
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0,3'd0,8'h00,0,   9,0,1,0,0,1,0)); // stall in redirect
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   9,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,1,3'd0,8'h03,1,   9,0,0,1,0,1,0)); // halt beats br
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   9,0,0,1,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,1,0)); // restart
        tbl.push_back(mk(0,0,1,1,0,1,0,0,0,3'd0,8'h00,0,   0,0,0,0,1,1,0)); // c during stall
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd5,8'h02,0,   2,1,1,0,1,1,0)); // bcs
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0)); // reset in redirect
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd0,8'h05,1,   0,0,0,0,0,0,0)); // idle ignores
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd0,8'hFC,0,1020,1,1,0,0,0,0)); // wrap down
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,1020,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd0,8'h0A,0,   6,1,1,0,0,0,0)); // wrap up
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   6,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd0,8'hF9,0,1023,1,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,1023,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0)); // seq wrap
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,3'd7,8'h05,0,   1,0,0,0,0,0,0)); // reserved
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,3'd0,8'h00,1,   1,0,0,1,0,0,0)); // halt
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,3'd0,8'h00,0,   0,0,0,0,0,0,0)); // reset in halted

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; start = tbl[i].st; stall = tbl[i].stl;
            alu_wr = tbl[i].aw; cmp_wr = tbl[i].cw; alu_c = tbl[i].c;
            alu_z = tbl[i].z; alu_n = tbl[i].n; br_valid = tbl[i].bv;
            br_cond = tbl[i].cond; br_off = tbl[i].off; halt = tbl[i].hlt;
            @(posedge clk);
            #1;
            compare($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_t, tbl[i].e_f,
                    tbl[i].e_d, tbl[i].e_c, tbl[i].e_z, tbl[i].e_n);
        end

        // Randomized phase: model resets together with the DUT on the first cycle.
        for (int i = 0; i < 3000; i++) begin
            reset    = (i == 0) || ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            alu_wr   = ($urandom_range(0, 2) == 0);
            cmp_wr   = ($urandom_range(0, 2) == 0);
            alu_c    = 1'($urandom);
            alu_z    = 1'($urandom);
            alu_n    = 1'($urandom);
            br_valid = ($urandom_range(0, 2) == 0);
            br_cond  = 3'($urandom);
            br_off   = 8'($urandom);
            halt     = ($urandom_range(0, 19) == 0);
            model_step();
            @(posedge clk);
            #1;
            compare($sformatf("rand%0d", i), m_pc, m_t, m_f, m_d, m_c, m_z, m_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
